// File: rtl/adc_event_packer_if.sv
// AXI4-Stream style bundle shared by the sample input and the DMA-facing output.
interface adc_event_packer_if #(
  parameter int DW = 64
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_event_packer.sv
// Buffers the free-running ADC sample stream in a FIFO and re-emits it as back-pressured
// packets, closing a packet at each event end and every BURST_LEN written words.
module adc_event_packer #(
  parameter int FIFO_AW   = 10,
  parameter int BURST_LEN = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 clear_stats,
  adc_event_packer_if.slave    s_axis,
  adc_event_packer_if.master   m_axis,
  output logic [FIFO_AW:0]     fifo_level,
  output logic [31:0]          dropped_count,
  output logic [15:0]          events_count,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(BURST_LEN);
  localparam logic [BW-1:0]    BCNT_TOP = BW'(BURST_LEN - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  logic [64:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_hold_v;
  logic [63:0]        r_hold_data;
  logic [BW-1:0]      r_bcnt;
  logic               r_pend_last, r_pend_ev;
  logic               r_out_v;
  logic [64:0]        r_out_data;
  logic [31:0]        r_dropped;
  logic [15:0]        r_events;
  logic               r_overflow;

  logic w_in, w_pop, w_full, w_last, w_wr, w_drop, w_ev_inc;
  logic w_unused;

  assign w_in     = s_axis.tvalid & enable;
  assign w_pop    = (~r_out_v | m_axis.tready) & (r_count != '0);
  assign w_full   = (r_count == LVL_FULL);
  assign w_last   = ~w_in | (r_bcnt == BCNT_TOP) | r_pend_last;
  // A same-edge read frees a slot, so a full FIFO only drops when nothing leaves it.
  assign w_wr     = r_hold_v & (~w_full | w_pop);
  assign w_drop   = r_hold_v & w_full & ~w_pop;
  assign w_ev_inc = w_wr & (~w_in | r_pend_ev);
  assign w_unused = s_axis.tlast;

  assign s_axis.tready = 1'b1;
  assign m_axis.tvalid = r_out_v;
  assign m_axis.tdata  = r_out_data[63:0];
  assign m_axis.tlast  = r_out_data[64];
  assign fifo_level    = r_count;
  assign dropped_count = r_dropped;
  assign events_count  = r_events;
  assign overflow      = r_overflow;

  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_last, r_hold_data};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hold_v    <= 1'b0;
      r_hold_data <= '0;
      r_bcnt      <= '0;
      r_pend_last <= 1'b0;
      r_pend_ev   <= 1'b0;
      r_out_v     <= 1'b0;
      r_out_data  <= '0;
      r_dropped   <= '0;
      r_events    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_hold_v <= w_in;
      if (w_in) r_hold_data <= s_axis.tdata;

      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_wr) begin
        r_bcnt      <= w_last ? '0 : r_bcnt + 1'b1;
        r_pend_last <= 1'b0;
        r_pend_ev   <= 1'b0;
      end else if (w_drop && w_last) begin
        // Carry the lost packet boundary (and whether it was an event end) to the next word.
        r_pend_last <= 1'b1;
        r_pend_ev   <= r_pend_ev | ~w_in;
      end

      if (w_pop) begin
        r_out_v    <= 1'b1;
        r_out_data <= r_mem[r_rd_ptr];
      end else if (m_axis.tready) begin
        r_out_v    <= 1'b0;
      end

      if (clear_stats) begin
        r_dropped  <= '0;
        r_events   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_dropped != '1) r_dropped <= r_dropped + 1'b1;
        end
        if (w_ev_inc && r_events != '1) r_events <= r_events + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_event_packer.sv
// Directed bench for adc_event_packer with a queue-based reference model compared every cycle.
module tb_adc_event_packer;
  localparam int DEPTH = 16;
  localparam int BL    = 16;

  logic aclk = 1'b0;
  logic aresetn, enable, clear_stats;
  logic [4:0]  fifo_level;
  logic [31:0] dropped_count;
  logic [15:0] events_count;
  logic        overflow;

  adc_event_packer_if #(.DW(64)) s_if ();
  adc_event_packer_if #(.DW(64)) m_if ();

  adc_event_packer #(.FIFO_AW(4), .BURST_LEN(BL)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear_stats(clear_stats),
    .s_axis(s_if), .m_axis(m_if), .fifo_level(fifo_level),
    .dropped_count(dropped_count), .events_count(events_count), .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: whole words move between a hold slot, a queue and an output slot.
  logic [64:0] mq [$];
  logic [64:0] log_q [$];
  logic        m_hold_v, m_out_v, m_pend, m_pend_ev, m_ov, m_in, m_pop, m_hs, m_lastb;
  logic [63:0] m_hold;
  logic [64:0] m_out;
  int          m_bcnt, m_drop, m_ev;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mq.delete();
      m_hold_v = 0; m_out_v = 0; m_pend = 0; m_pend_ev = 0; m_ov = 0;
      m_hold = '0; m_out = '0; m_bcnt = 0; m_drop = 0; m_ev = 0;
    end else begin
      m_in  = s_if.tvalid & enable;
      m_hs  = m_out_v & m_if.tready;
      m_pop = (!m_out_v || m_if.tready) && mq.size() > 0;
      if (m_hs) log_q.push_back(m_out);
      if (m_pop) begin
        m_out = mq.pop_front();
        m_out_v = 1;
      end else if (m_hs) m_out_v = 0;
      if (m_hold_v) begin
        m_lastb = !m_in || (m_bcnt == BL - 1) || m_pend;
        if (mq.size() < DEPTH) begin
          mq.push_back({m_lastb, m_hold});
          if (!m_in || m_pend_ev) m_ev = m_ev + 1;
          m_bcnt = m_lastb ? 0 : m_bcnt + 1;
          m_pend = 0; m_pend_ev = 0;
        end else begin
          m_drop = m_drop + 1; m_ov = 1;
          if (m_lastb) begin
            m_pend = 1;
            m_pend_ev = m_pend_ev | !m_in;
          end
        end
      end
      if (clear_stats) begin
        m_drop = 0; m_ev = 0; m_ov = 0;
      end
      m_hold_v = m_in;
      if (m_in) m_hold = s_if.tdata;
    end
  end

  logic        stall_prev = 0;
  logic [64:0] out_prev;

  always @(negedge aclk) begin
    check("tvalid", m_if.tvalid, m_out_v);
    if (m_out_v) begin
      check("tdata", m_if.tdata, m_out[63:0]);
      check("tlast", m_if.tlast, m_out[64]);
    end
    check("fifo_level", fifo_level, mq.size());
    check("dropped_count", dropped_count, m_drop);
    check("events_count", events_count, m_ev);
    check("overflow", overflow, m_ov);
    if (stall_prev && aresetn) begin
      check("stall_hold", {m_if.tlast, m_if.tdata}, out_prev);
      check("stall_valid", m_if.tvalid, 1'b1);
    end
    stall_prev = aresetn && m_if.tvalid && !m_if.tready;
    out_prev   = {m_if.tlast, m_if.tdata};
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_stats = 1; tick(); clear_stats = 0;
  endtask

  task automatic drain();
    int n = 0;
    s_if.tvalid = 0;
    m_if.tready = 1;
    while ((mq.size() != 0 || m_hold_v || m_out_v) && n < 400) begin
      tick(); n++;
    end
    check("drain_timeout", (n >= 400), 1'b0);
  endtask

  task automatic send(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      s_if.tvalid = 1; s_if.tdata = base + 64'(i);
      tick();
    end
  endtask

  task automatic check_lasts(input string name, input int exp_pos[$]);
    int pos[$];
    for (int i = 0; i < log_q.size(); i++) if (log_q[i][64]) pos.push_back(i + 1);
    check({name, "_nlast"}, pos.size(), exp_pos.size());
    for (int i = 0; i < exp_pos.size() && i < pos.size(); i++)
      check({name, "_lastpos"}, pos[i], exp_pos[i]);
  endtask

  initial begin
    logic rz;
    aresetn = 0; enable = 1; clear_stats = 0;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0; m_if.tready = 1;
    repeat (3) tick();
    check("rst_level", fifo_level, 0);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_dropped", dropped_count, 0);
    aresetn = 1;
    tick();

    // 1: five-word event, latency and single TLAST
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1; s_if.tdata = 64'hA000 + 64'(i);
      tick();
      if (i < 2) check("lat_idle", m_if.tvalid, 1'b0);
      if (i == 2) begin
        check("lat_valid", m_if.tvalid, 1'b1);
        check("lat_d0", m_if.tdata, 64'hA000);
      end
    end
    drain();
    check("t1_count", log_q.size(), 5);
    check("t1_d4", log_q[4][63:0], 64'hA004);
    check_lasts("t1", '{5});
    check("t1_events", events_count, 1);

    // 2: forty-word event closes packets at 16, 32, 40
    pulse_clear(); log_q.delete();
    send(40, 64'hB000);
    drain();
    check("t2_count", log_q.size(), 40);
    check_lasts("t2", '{16, 32, 40});
    check("t2_events", events_count, 1);

    // 3: stalled output overflows the 16-deep FIFO
    pulse_clear(); log_q.delete();
    m_if.tready = 0;
    send(30, 64'hC000);
    check("t3_level", fifo_level, 16);
    check("t3_dropped", dropped_count, 12);
    check("t3_overflow", overflow, 1);
    drain();
    check("t3_count", log_q.size(), 18);
    check("t3_last_data", log_q[17][63:0], 64'hC000 + 64'd29);
    check("t3_last_flag", log_q[17][64], 1'b1);
    check("t3_events", events_count, 1);

    // 4: random back-pressure, ten 20-word events, no loss
    pulse_clear(); log_q.delete();
    rz = 0;
    for (int e = 0; e < 10; e++) begin
      for (int i = 0; i < 50; i++) begin
        s_if.tvalid = (i < 20);
        s_if.tdata  = 64'hD000 + 64'(e * 20 + i);
        m_if.tready = rz ? 1'b1 : 1'($urandom_range(0, 1));
        rz = !m_if.tready;
        tick();
      end
    end
    drain();
    check("t4_count", log_q.size(), 200);
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i][63:0] !== 64'hD000 + 64'(i)) check("t4_order", log_q[i][63:0], 64'hD000 + 64'(i));
    check("t4_dropped", dropped_count, 0);
    check("t4_events", events_count, 10);

    // 5: enable falls after 7 words while tvalid stays high
    pulse_clear(); log_q.delete();
    send(7, 64'hE000);
    enable = 0;
    send(5, 64'hE007);
    check("t5_level_gated", fifo_level + 5'(m_out_v), 0);
    s_if.tvalid = 0; enable = 1;
    drain();
    check("t5_count", log_q.size(), 7);
    check_lasts("t5", '{7});
    check("t5_events", events_count, 1);

    // 6: clear on the same edge as a drop, then reset mid-burst
    pulse_clear(); log_q.delete();
    m_if.tready = 0;
    send(20, 64'hF000);
    check("t6_pre_drop", dropped_count, 2);
    clear_stats = 1;
    send(1, 64'hF014);
    clear_stats = 0;
    check("t6_clr_dropped", dropped_count, 0);
    check("t6_clr_overflow", overflow, 0);
    m_if.tready = 1;
    send(3, 64'hF015);
    #3 aresetn = 0;
    #1;
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_tvalid", m_if.tvalid, 0);
    check("t6_rst_dropped", dropped_count, 0);
    s_if.tvalid = 0;
    tick();
    aresetn = 1;
    tick();
    log_q.delete();
    send(3, 64'h1234_0000);
    drain();
    check("t6_restart_count", log_q.size(), 3);
    check("t6_restart_d0", log_q[0][63:0], 64'h1234_0000);
    check_lasts("t6", '{3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
